// File: rtl/execute_pipe.sv
// Y86 execute stage with valid/ready output register and architectural flags.
// Build option: define EXEC_MUL_EN to enable OPq ifun 4, an iterative signed multiply.
module execute_pipe #(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic             out_err,
  output logic [2:0]       cc
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_icode_q, out_icode_d;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic             cnd_q, cnd_d;
  logic             out_err_q, out_err_d;
  logic [2:0]       cc_q, cc_d;

  logic [WIDTH-1:0] alu_val;
  logic             alu_cnd, alu_err, alu_setcc, alu_of;
  logic             accept, is_mul;

  // cc is {ZF,SF,OF}
  function automatic logic cond_ok(input logic [3:0] f, input logic [2:0] c);
    logic zf, sf, of;
    zf = c[2];
    sf = c[1];
    of = c[0];
    case (f)
      4'd1:    cond_ok = (sf ^ of) | zf;
      4'd2:    cond_ok = sf ^ of;
      4'd3:    cond_ok = zf;
      4'd4:    cond_ok = !zf;
      4'd5:    cond_ok = !(sf ^ of);
      4'd6:    cond_ok = !(sf ^ of) && !zf;
      default: cond_ok = 1'b1;
    endcase
  endfunction

  always_comb begin
    alu_val   = '0;
    alu_cnd   = 1'b1;
    alu_err   = 1'b0;
    alu_setcc = 1'b0;
    alu_of    = 1'b0;
    case (icode)
      4'h0, 4'h1: ;
      4'h2, 4'h7: begin
        if (icode == 4'h2) alu_val = valA;
        if (ifun > 4'd6) alu_err = 1'b1;
        else             alu_cnd = cond_ok(ifun, cc_q);
      end
      4'h3:       alu_val = valC;
      4'h4, 4'h5: alu_val = valB + valC;
      4'h6: begin
        alu_setcc = 1'b1;
        case (ifun)
          4'd0: begin
            alu_val = valB + valA;
            alu_of  = (valA[MSB] == valB[MSB]) && (alu_val[MSB] != valB[MSB]);
          end
          4'd1: begin
            alu_val = valB - valA;
            alu_of  = (valA[MSB] != valB[MSB]) && (alu_val[MSB] != valB[MSB]);
          end
          4'd2: alu_val = valB & valA;
          4'd3: alu_val = valB ^ valA;
`ifdef EXEC_MUL_EN
          4'd4: alu_setcc = 1'b0;
`endif
          default: alu_err = 1'b1;
        endcase
      end
      4'h8, 4'hA: alu_val = valB - STEP;
      4'h9, 4'hB: alu_val = valB + STEP;
      default:    alu_err = 1'b1;
    endcase
    // Invalid instructions must leave no trace besides the error marker.
    if (alu_err) begin
      alu_val   = '0;
      alu_cnd   = 1'b0;
      alu_setcc = 1'b0;
      alu_of    = 1'b0;
    end
  end

`ifdef EXEC_MUL_EN
  // state | meaning
  // IDLE  | accepting; single-cycle ops go straight to the output register
  // MUL   | shift-add multiply, one multiplier bit per cycle, then capture
  typedef enum logic {IDLE, MUL} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [WIDTH-1:0]   mplier_q, mplier_d, abs_a, abs_b;
  logic               neg_q, neg_d, prod_of;

  assign is_mul   = (icode == 4'h6) && (ifun == 4'd4);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign abs_a    = valA[MSB] ? (~valA + 1'b1) : valA;
  assign abs_b    = valB[MSB] ? (~valB + 1'b1) : valB;
  assign prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
  // Product fits signed WIDTH only if the upper half is a sign extension of bit MSB.
  assign prod_of  = !((&prod[2*WIDTH-1:MSB]) || !(|prod[2*WIDTH-1:MSB]));
`else
  assign is_mul   = 1'b0;
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_icode_d = out_icode_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    out_err_d   = out_err_q;
    cc_d        = cc_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      out_icode_d = icode;
      vale_d      = alu_val;
      cnd_d       = alu_cnd;
      out_err_d   = alu_err;
      if (alu_setcc) cc_d = {alu_val == '0, alu_val[MSB], alu_of};
    end
`ifdef EXEC_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: if (accept && is_mul) begin
        state_d  = MUL;
        cnt_d    = CW'(WIDTH);
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, abs_b};
        mplier_d = abs_a;
        neg_d    = valA[MSB] ^ valB[MSB];
      end
      MUL: if (cnt_q != '0) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_icode_d = 4'h6;
        vale_d      = prod[WIDTH-1:0];
        cnd_d       = 1'b1;
        out_err_d   = 1'b0;
        cc_d        = {prod[WIDTH-1:0] == '0, prod[MSB], prod_of};
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_icode_q <= 4'h0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      out_err_q   <= 1'b0;
      cc_q        <= 3'b100;
`ifdef EXEC_MUL_EN
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      out_err_q   <= out_err_d;
      cc_q        <= cc_d;
`ifdef EXEC_MUL_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign valE      = vale_q;
  assign cnd       = cnd_q;
  assign out_err   = out_err_q;
  assign cc        = cc_q;
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe (WIDTH=64); multiply steps only when EXEC_MUL_EN is defined.
module tb_execute_pipe;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   icode, ifun, out_icode;
  logic [W-1:0] valA, valB, valC, valE;
  logic         cnd, out_err;
  logic [2:0]   cc;

  int errors = 0;
  int checks = 0;

  execute_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .valE(valE), .cnd(cnd), .out_err(out_err), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one instruction for one edge and returns at the next negedge.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_valE", valE, 0);
    chk("rst_cnd", cnd, 0);
    chk("rst_err", out_err, 0);
    chk("rst_icode", out_icode, 0);
    chk("rst_cc", cc, 3'b100);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    issue(4'h6, 4'h0, 3, 5, 0);
    chk("add_valE", valE, 8);
    chk("add_cc", cc, 3'b000);
    chk("add_valid", out_valid, 1);
    chk("add_icode", out_icode, 6);

    issue(4'h6, 4'h1, 5, 5, 0);
    chk("sub_valE", valE, 0);
    chk("sub_cc", cc, 3'b100);
    issue(4'h2, 4'h1, 7, 0, 0);
    chk("cmovle_cnd", cnd, 1);
    chk("cmovle_valE", valE, 7);

    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    chk("addovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("addovf_cc", cc, 3'b011);
    issue(4'h7, 4'h2, 0, 0, 0);
    chk("jl_cnd", cnd, 0);
    chk("jl_valE", valE, 0);
    issue(4'h7, 4'h6, 0, 0, 0);
    chk("jg_cnd", cnd, 1);
    issue(4'h7, 4'h3, 0, 0, 0);
    chk("je_cnd", cnd, 0);

    issue(4'hA, 4'h0, 0, 64'h100, 0);
    chk("push_valE", valE, 64'hF8);
    issue(4'hB, 4'h0, 0, 64'hF8, 0);
    chk("pop_valE", valE, 64'h100);
    chk("pop_icode", out_icode, 4'hB);

    out_ready = 1'b0;
    icode = 4'h1; ifun = 4'h0; valA = 9; valB = 9; valC = 9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valE", valE, 64'h100);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("nop_icode", out_icode, 4'h1);
    chk("nop_valE", valE, 0);

    issue(4'hC, 4'h0, 1, 2, 3);
    chk("badic_err", out_err, 1);
    chk("badic_valE", valE, 0);
    chk("badic_cnd", cnd, 0);
    chk("badic_cc", cc, 3'b011);
    issue(4'h6, 4'h5, 1, 1, 0);
    chk("badop_err", out_err, 1);
    chk("badop_cc", cc, 3'b011);
    issue(4'h2, 4'h7, 1, 1, 0);
    chk("badcmov_err", out_err, 1);
`ifndef EXEC_MUL_EN
    issue(4'h6, 4'h4, 1, 1, 0);
    chk("nomul_err", out_err, 1);
    chk("nomul_cc", cc, 3'b011);
`endif

    issue(4'h3, 4'h0, 0, 0, 64'h1234);
    chk("irmov_valE", valE, 64'h1234);
    chk("irmov_err", out_err, 0);
    issue(4'h5, 4'h0, 0, 64'h10, 64'h8);
    chk("mrmov_valE", valE, 64'h18);
    issue(4'h6, 4'h2, 64'hF0, 64'h0F, 0);
    chk("and_cc", cc, 3'b100);
    issue(4'h6, 4'h1, 1, 0, 0);
    chk("sub_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_neg_cc", cc, 3'b010);
    issue(4'h8, 4'h0, 0, 64'h0, 0);
    chk("call_wrap_valE", valE, 64'hFFFF_FFFF_FFFF_FFF8);

    @(negedge clk);
    chk("drain_valid", out_valid, 0);

`ifdef EXEC_MUL_EN
    issue(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFD, 7, 0);
    chk("mul_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mul_latency", n, W + 1);
    chk("mul_valE", valE, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_cc", cc, 3'b010);

    issue(4'h6, 4'h4, 5, 6, 0);
    repeat (9) @(negedge clk);
    chk("mul2_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mulrst_valid", out_valid, 0);
    chk("mulrst_valE", valE, 0);
    chk("mulrst_cc", cc, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mulrst_in_ready", in_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
